// File: rtl/seqdiv512_if.sv
// Purpose: request/result bundle for the seqdiv512 sequential divider.
// Signals:
//   start    - request pulse, honoured only while the divider is idle
//   dividend - 2N-bit numerator, sampled on the accepting edge
//   divisor  - N-bit denominator, sampled on the accepting edge
//   quot     - 2N-bit quotient of the last completed request
//   rem      - N-bit remainder of the last completed request
//   data_rdy - quot/rem/dbz are valid for the last accepted request
//   busy     - an operation is in flight (RUN or DONE)
//   dbz      - last result was a divide by zero
//   state    - FSM state: IDLE=0, RUN=1, DONE=2
// Modports: master drives requests, slave is the divider.
interface seqdiv512_if #(
  parameter int unsigned N = 256
) ();
  logic             start;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic [2*N-1:0]   quot;
  logic [N-1:0]     rem;
  logic             data_rdy;
  logic             busy;
  logic             dbz;
  logic [1:0]       state;

  modport master (
    output start, dividend, divisor,
    input  quot, rem, data_rdy, busy, dbz, state
  );

  modport slave (
    input  start, dividend, divisor,
    output quot, rem, data_rdy, busy, dbz, state
  );
endinterface

// File: rtl/seqdiv512.sv
// Purpose: sequential restoring divider, 2N-bit dividend / N-bit divisor,
//   producing a 2N-bit quotient and N-bit remainder, one quotient bit per
//   clock, MSB first.
// Ports:
//   clk - clock, everything on posedge
//   rst - synchronous active-low reset
//   bus - seqdiv512_if.slave (start/operands in; quot/rem/data_rdy/busy/dbz/state out)
// Build option: SEQDIV512_EARLY_EXIT_EN - when defined, a request whose
//   dividend is smaller than a nonzero divisor completes in one cycle.
module seqdiv512 #(
  parameter int unsigned N = 256
) (
  input  logic        clk,
  input  logic        rst,
  seqdiv512_if.slave  bus
);

  localparam int unsigned W  = 2 * N;
  localparam int unsigned CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;

  logic [W-1:0]     r_q_sh;
  logic [N-1:0]     r_r;
  logic [N-1:0]     r_dvsr;
  logic [CW-1:0]    r_cnt;
  logic             r_zero;
  logic [W-1:0]     r_quot;
  logic [N-1:0]     r_rem;
  logic             r_data_rdy;
  logic             r_busy;
  logic             r_dbz;

  logic             w_div_zero;
  logic             w_early;
  logic [N:0]       w_r_sh;
  logic             w_ge;
  logic [N-1:0]     w_r_nxt;
  logic [W-1:0]     w_q_nxt;
  logic [CW-1:0]    w_cnt_inc;

  assign w_div_zero = (bus.divisor == '0);

`ifdef SEQDIV512_EARLY_EXIT_EN
  // Quotient is zero whenever the dividend is below the divisor.
  assign w_early = (bus.dividend < {{N{1'b0}}, bus.divisor});
`else
  assign w_early = 1'b0;
`endif

  // One restoring step; the N+1-bit shifted remainder cannot overflow the
  // compare, and the difference is always below the divisor so N bits hold it.
  assign w_r_sh    = {r_r, r_q_sh[W-1]};
  assign w_ge      = (w_r_sh >= {1'b0, r_dvsr});
  assign w_r_nxt   = w_ge ? (w_r_sh[N-1:0] - r_dvsr) : w_r_sh[N-1:0];
  assign w_q_nxt   = {r_q_sh[W-2:0], w_ge};
  assign w_cnt_inc = r_cnt + CW'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_div_zero || w_early) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_cnt_inc == CW'(W)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q_sh     <= '0;
      r_r        <= '0;
      r_dvsr     <= '0;
      r_cnt      <= '0;
      r_zero     <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_data_rdy <= 1'b0;
      r_busy     <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == RUN) || (w_state_nxt == DONE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_data_rdy <= 1'b0;
            r_dbz      <= 1'b0;
            r_dvsr     <= bus.divisor;
            r_cnt      <= '0;
            r_zero     <= w_div_zero;
            // Short-circuit cases preload the final result so DONE is uniform.
            if (w_div_zero) begin
              r_q_sh <= '1;
              r_r    <= bus.dividend[N-1:0];
            end else if (w_early) begin
              r_q_sh <= '0;
              r_r    <= bus.dividend[N-1:0];
            end else begin
              r_q_sh <= bus.dividend;
              r_r    <= '0;
            end
          end
        end
        RUN: begin
          r_q_sh <= w_q_nxt;
          r_r    <= w_r_nxt;
          r_cnt  <= w_cnt_inc;
        end
        DONE: begin
          r_quot     <= r_q_sh;
          r_rem      <= r_r;
          r_dbz      <= r_zero;
          r_data_rdy <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.quot     = r_quot;
  assign bus.rem      = r_rem;
  assign bus.data_rdy = r_data_rdy;
  assign bus.busy     = r_busy;
  assign bus.dbz      = r_dbz;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_seqdiv512.sv
// Purpose: directed, table-driven check of seqdiv512 plus hand-written
//   sequences for busy-start, back-to-back start and mid-run reset.
module tb_seqdiv512;

  localparam int unsigned N = 256;
  localparam int unsigned W = 2 * N;
  localparam int unsigned NV = 10;

`ifdef SEQDIV512_EARLY_EXIT_EN
  localparam int LAT_SMALL = 1;
`else
  localparam int LAT_SMALL = 513;
`endif

  typedef struct {
    logic [W-1:0] dvd;
    logic [N-1:0] dvs;
    logic [W-1:0] q;
    logic [N-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  seqdiv512_if #(.N(N)) bus ();

  seqdiv512 #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Present a request for one edge, then wait (bounded) for data_rdy.
  task automatic do_op(input string nm, input logic [W-1:0] dvd, input logic [N-1:0] dvs,
                       output int cyc);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({nm, "_busy_on_accept"}, W'(bus.busy), W'(1));
    chk({nm, "_rdy_drop"}, W'(bus.data_rdy), W'(0));
    cyc = 0;
    while (bus.data_rdy !== 1'b1 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic chk_result(input string nm, input vec_t v, input int cyc);
    chk({nm, "_quot"}, bus.quot, v.q);
    chk({nm, "_rem"}, W'(bus.rem), W'(v.r));
    chk({nm, "_dbz"}, W'(bus.dbz), W'(v.z));
    chk({nm, "_lat"}, W'(cyc), W'(v.lat));
    chk({nm, "_busy_end"}, W'(bus.busy), W'(0));
    chk({nm, "_state_end"}, W'(bus.state), W'(0));
  endtask

  vec_t vt [NV];

  initial begin
    logic [W-1:0] m;
    logic [W-1:0] p511;
    logic [W-1:0] p256;
    logic [W-1:0] q511;
    int           cyc;
    vec_t         t1;
    vec_t         tz;

    m    = {{N{1'b0}}, {N{1'b1}}};
    p511 = W'(1) << 511;
    p256 = W'(1) << 256;
    q511 = {4'h2, {127{4'hA}}};

    vt[0] = '{W'(100),   N'(7),         W'(14),    N'(2),      1'b0, 513};
    vt[1] = '{m * m,     {N{1'b1}},     m,         N'(0),      1'b0, 513};
    vt[2] = '{p511,      N'(3),         q511,      N'(2),      1'b0, 513};
    vt[3] = '{W'(16'hDEAD), N'(0),      {W{1'b1}}, N'(16'hDEAD), 1'b1, 1};
    vt[4] = '{W'(5),     N'(9),         W'(0),     N'(5),      1'b0, LAT_SMALL};
    vt[5] = '{W'(1000),  N'(1000),      W'(1),     N'(0),      1'b0, 513};
    vt[6] = '{p256,      N'(1) << 255,  W'(2),     N'(0),      1'b0, 513};
    vt[7] = '{{N'(1), N'(16'hBEEF)}, N'(0), {W{1'b1}}, N'(16'hBEEF), 1'b1, 1};
    vt[8] = '{W'(12345), N'(1),         W'(12345), N'(0),      1'b0, 513};
    vt[9] = '{W'(0),     N'(7),         W'(0),     N'(0),      1'b0, LAT_SMALL};
    t1 = vt[0];
    tz = vt[3];

    // Reset state.
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_quot", bus.quot, W'(0));
    chk("rst_rem", W'(bus.rem), W'(0));
    chk("rst_rdy", W'(bus.data_rdy), W'(0));
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_dbz", W'(bus.dbz), W'(0));
    chk("rst_state", W'(bus.state), W'(0));

    // Vector table.
    for (int i = 0; i < int'(NV); i++) begin
      do_op($sformatf("v%0d", i), vt[i].dvd, vt[i].dvs, cyc);
      chk_result($sformatf("v%0d", i), vt[i], cyc);
    end

    // Start during RUN is ignored.
    bus.start    = 1'b1;
    bus.dividend = t1.dvd;
    bus.divisor  = t1.dvs;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    repeat (50) begin @(posedge clk); #1; cyc++; end
    chk("busy_mid_run", W'(bus.state), W'(1));
    bus.start    = 1'b1;
    bus.dividend = W'(999);
    bus.divisor  = N'(0);
    @(posedge clk); #1;
    cyc++;
    bus.start = 1'b0;
    while (bus.data_rdy !== 1'b1 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk_result("ign", t1, cyc);

    // Back-to-back start in the data_rdy cycle.
    bus.start    = 1'b1;
    bus.dividend = tz.dvd;
    bus.divisor  = tz.dvs;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_rdy_drop", W'(bus.data_rdy), W'(0));
    chk("b2b_quot_hold", bus.quot, t1.q);
    chk("b2b_rem_hold", W'(bus.rem), W'(t1.r));
    chk("b2b_state", W'(bus.state), W'(2));
    chk("b2b_busy", W'(bus.busy), W'(1));
    @(posedge clk); #1;
    chk_result("b2b", tz, 1);
    chk("b2b_rdy", W'(bus.data_rdy), W'(1));

    // Mid-run reset abandons the op.
    bus.start    = 1'b1;
    bus.dividend = t1.dvd;
    bus.divisor  = t1.dvs;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("mrst_state", W'(bus.state), W'(0));
    chk("mrst_quot", bus.quot, W'(0));
    chk("mrst_rem", W'(bus.rem), W'(0));
    chk("mrst_rdy", W'(bus.data_rdy), W'(0));
    chk("mrst_busy", W'(bus.busy), W'(0));
    chk("mrst_dbz", W'(bus.dbz), W'(0));
    do_op("post_rst", t1.dvd, t1.dvs, cyc);
    chk_result("post_rst", t1, cyc);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
